// File: rtl/round_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : round_scheduler_if
// Description : Host/step-unit handshake bundle of the permutation round
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface round_scheduler_if;
   logic       start;
   logic [4:0] stepDone;
   logic [4:0] stepStart;
   logic [2:0] memSel;
   logic       swapBuf;
   logic [4:0] round;
   logic [2:0] step;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output start,
      output stepDone,
      input  stepStart,
      input  memSel,
      input  swapBuf,
      input  round,
      input  step,
      input  busy,
      input  done,
      input  err
   );

   modport slave (
      input  start,
      input  stepDone,
      output stepStart,
      output memSel,
      output swapBuf,
      output round,
      output step,
      output busy,
      output done,
      output err
   );
endinterface
`default_nettype wire

// File: rtl/round_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : round_scheduler
// Description : Sequences ROUNDS rounds of the five permutation step units,
//               owning the state-memory grant and ping-pong buffer swaps.
// Revision    : 1.0 - initial release
// ============================================================================
module round_scheduler #(
   parameter int ROUNDS  = 24,
   parameter int TIMEOUT = 63
) (
   input  wire logic        clk,
   input  wire logic        rst,
   round_scheduler_if.slave bus
);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_LAUNCH  = 3'd1;
   localparam logic [2:0] c_WAIT    = 3'd2;
   localparam logic [2:0] c_ADVANCE = 3'd3;
   localparam logic [2:0] c_FINISH  = 3'd4;
   localparam logic [2:0] c_ERROR   = 3'd5;

   localparam logic [4:0] c_LAST_ROUND = 5'(ROUNDS - 1);
   localparam logic [2:0] c_LAST_STEP  = 3'd4;
   localparam logic [5:0] c_WAIT_LAST  = 6'(TIMEOUT - 1);

   logic [2:0] r_state;
   logic [4:0] r_round;
   logic [2:0] r_step;
   logic [5:0] r_wait;

   logic [2:0] w_state_nxt;
   logic [4:0] w_round_nxt;
   logic [2:0] w_step_nxt;
   logic [5:0] w_wait_nxt;
   logic [4:0] w_expect;
   logic       w_busy;

   assign w_expect = 5'b00001 << r_step;

   always_comb begin
      w_state_nxt = r_state;
      w_round_nxt = r_round;
      w_step_nxt  = r_step;
      w_wait_nxt  = r_wait;
      case (r_state)
         c_IDLE: begin
            if (bus.start) begin
               w_state_nxt = c_LAUNCH;
               w_round_nxt = 5'd0;
               w_step_nxt  = 3'd0;
               w_wait_nxt  = 6'd0;
            end
         end
         c_LAUNCH: begin
            w_wait_nxt  = 6'd0;
            w_state_nxt = c_WAIT;
         end
         c_WAIT: begin
            // A correct done wins even on the last permitted wait cycle.
            if (bus.stepDone == w_expect) begin
               w_state_nxt = c_ADVANCE;
            end else if (bus.stepDone != 5'd0) begin
               w_state_nxt = c_ERROR;
            end else if (r_wait == c_WAIT_LAST) begin
               w_state_nxt = c_ERROR;
            end else begin
               w_wait_nxt = r_wait + 6'd1;
            end
         end
         c_ADVANCE: begin
            if (r_step < c_LAST_STEP) begin
               w_step_nxt  = r_step + 3'd1;
               w_state_nxt = c_LAUNCH;
            end else if (r_round < c_LAST_ROUND) begin
               w_step_nxt  = 3'd0;
               w_round_nxt = r_round + 5'd1;
               w_state_nxt = c_LAUNCH;
            end else begin
               w_state_nxt = c_FINISH;
            end
         end
         c_FINISH: begin
            w_state_nxt = c_IDLE;
         end
         c_ERROR: begin
            if (bus.start) begin
               w_state_nxt = c_IDLE;
            end
         end
         default: begin
            w_state_nxt = c_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_round <= 5'd0;
         r_step  <= 3'd0;
         r_wait  <= 6'd0;
      end else begin
         r_state <= w_state_nxt;
         r_round <= w_round_nxt;
         r_step  <= w_step_nxt;
         r_wait  <= w_wait_nxt;
      end
   end

   assign w_busy = (r_state == c_LAUNCH) || (r_state == c_WAIT) ||
                   (r_state == c_ADVANCE) || (r_state == c_FINISH);

   assign bus.stepStart = (r_state == c_LAUNCH) ? w_expect : 5'd0;
   assign bus.memSel    = w_busy ? r_step : 3'd0;
   assign bus.swapBuf   = (r_state == c_ADVANCE);
   assign bus.round     = r_round;
   assign bus.step      = r_step;
   assign bus.busy      = w_busy;
   assign bus.done      = (r_state == c_FINISH);
   assign bus.err       = (r_state == c_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_round_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_round_scheduler
// Description : Self-checking bench for round_scheduler (ROUNDS=2, TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_scheduler;

   localparam int ROUNDS  = 2;
   localparam int TIMEOUT = 8;
   localparam int NSTEPS  = 5 * ROUNDS;

   typedef struct {
      int         k;
      int         fkind;      // 0 none, 1 wrong unit, 2 no answer
      int         fat;
      logic [4:0] wpat;
      int         exp_done;
      int         exp_err;
      int         exp_swaps;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   round_scheduler_if bus ();

   round_scheduler #(
      .ROUNDS  (ROUNDS),
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_vec = 0;
   int         n_bad = 0;
   int         k_lat [NSTEPS];
   int         launch[NSTEPS];
   int         fkind;
   int         fat;
   logic [4:0] wpat;
   bit         noise;
   bit         in_error;
   vec_t       tbl[7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".stepStart"}, bus.stepStart, 0);
      chk({tag, ".memSel"},    bus.memSel,    0);
      chk({tag, ".swapBuf"},   bus.swapBuf,   0);
      chk({tag, ".round"},     bus.round,     0);
      chk({tag, ".step"},      bus.step,      0);
      chk({tag, ".busy"},      bus.busy,      0);
      chk({tag, ".done"},      bus.done,      0);
      chk({tag, ".err"},       bus.err,       0);
   endtask

   task automatic clear_err();
      if (in_error) begin
         bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         @(negedge clk);
         chk("err_cleared", bus.err, 0);
         chk("busy_after_clear", bus.busy, 0);
         @(posedge clk); #1;
         in_error = 1'b0;
      end
   endtask

   // Open-loop run: the whole timeline is derived from the per-step latencies,
   // then every output is compared every cycle against that timeline.
   task automatic run_check(output int got_done, output int got_err, output int got_swaps);
      int t, d, errc, endc, last;
      int er, es, eb, ess, esw, edn, eer;
      logic [4:0] sd;
      last = (fkind != 0) ? fat : NSTEPS - 1;
      t = 1;
      for (int i = 0; i < NSTEPS; i++) begin
         launch[i] = t;
         t += k_lat[i] + 2;
      end
      d    = t;
      errc = (fkind == 1) ? launch[fat] + k_lat[fat] + 1 :
             (fkind == 2) ? launch[fat] + 1 + TIMEOUT : 0;
      endc = ((fkind != 0) ? errc : d) + 2;
      got_done  = -1;
      got_err   = -1;
      got_swaps = 0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= endc; c++) begin
         bus.start = 1'b0;
         sd  = 5'd0;
         er  = 0; es = 0; eb = 0; ess = 0; esw = 0; edn = 0; eer = 0;
         for (int i = 0; i <= last; i++) begin
            int  hi;
            bit  faulty;
            faulty = (fkind != 0) && (i == fat);
            hi = faulty ? errc - 1 : launch[i] + k_lat[i] + 1;
            if (c >= launch[i] && c <= hi) begin
               eb = 1; er = i / 5; es = i % 5;
            end
            if (c == launch[i]) ess = 1 << (i % 5);
            if (!faulty && c == hi) esw = 1;
            if (c == launch[i] + k_lat[i]) begin
               if (fkind == 1 && faulty) sd = wpat;
               else if (!faulty) sd = 5'(1 << (i % 5));
            end else if (noise && (c == launch[i] || (!faulty && c == hi)) &&
                         $urandom_range(0, 1) == 1) begin
               sd = 5'($urandom_range(1, 31));
            end
         end
         if (fkind == 0) begin
            if (c == d) begin
               eb = 1; edn = 1; er = ROUNDS - 1; es = 4;
            end else if (c > d) begin
               er = ROUNDS - 1; es = 4;
            end
         end else if (c >= errc) begin
            eer = 1; eb = 0; er = fat / 5; es = fat % 5;
         end
         if (noise && c < ((fkind != 0) ? errc - 1 : d) && $urandom_range(0, 7) == 0)
            bus.start = 1'b1;
         bus.stepDone = sd;
         @(negedge clk);
         chk("stepStart", bus.stepStart, ess);
         chk("swapBuf",   bus.swapBuf,   esw);
         chk("done",      bus.done,      edn);
         chk("err",       bus.err,       eer);
         chk("busy",      bus.busy,      eb);
         chk("round",     bus.round,     er);
         chk("step",      bus.step,      es);
         chk("memSel",    bus.memSel,    eb ? es : 0);
         if (bus.done === 1'b1 && got_done < 0) got_done = c;
         if (bus.err === 1'b1 && got_err < 0) got_err = c;
         if (bus.swapBuf === 1'b1) got_swaps++;
         @(posedge clk); #1;
      end
      bus.start    = 1'b0;
      bus.stepDone = 5'd0;
      in_error     = (fkind != 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int gd, ge, gs;
      logic [4:0] pat;
      // k, fault kind, fault step, wrong pattern, done cycle, err cycle, swaps
      tbl[0] = '{3, 0, 0, 5'b00000,  51, -1, 10};
      tbl[1] = '{1, 0, 0, 5'b00000,  31, -1, 10};
      tbl[2] = '{8, 0, 0, 5'b00000, 101, -1, 10};
      tbl[3] = '{3, 2, 0, 5'b00000,  -1, 10,  0};
      tbl[4] = '{3, 1, 2, 5'b00010,  -1, 15,  2};
      tbl[5] = '{2, 2, 7, 5'b00000,  -1, 38,  7};
      tbl[6] = '{1, 1, 4, 5'b10001,  -1, 15,  4};

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.stepDone = 5'd0;
      in_error     = 1'b0;
      noise        = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;

      // Early done in LAUNCH and start while busy are both ignored.
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.stepDone = 5'b00001;
      @(negedge clk);
      chk("early.launch_pulse", bus.stepStart, 5'b00001);
      @(posedge clk); #1;
      bus.stepDone = 5'd0;
      @(negedge clk);
      chk("early.busy_c2", bus.busy, 1);
      chk("early.swap_c2", bus.swapBuf, 0);
      @(posedge clk); #1;
      bus.start = 1'b1;
      @(negedge clk);
      chk("early.no_relaunch_c3", bus.stepStart, 0);
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.stepDone = 5'b00001;
      @(negedge clk);
      chk("early.swap_c4", bus.swapBuf, 0);
      chk("early.err_c4", bus.err, 0);
      @(posedge clk); #1;
      bus.stepDone = 5'd0;
      @(negedge clk);
      chk("early.advance_c5", bus.swapBuf, 1);
      chk("early.step_c5", bus.step, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("early.launch1_c6", bus.stepStart, 5'b00010);
      chk("early.step_c6", bus.step, 1);
      @(posedge clk); #1;
      // Mid-WAIT reset held for two edges.
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_all_zero("midreset");
      @(posedge clk); #1;

      foreach (tbl[v]) begin
         clear_err();
         for (int i = 0; i < NSTEPS; i++) k_lat[i] = tbl[v].k;
         fkind = tbl[v].fkind;
         fat   = tbl[v].fat;
         wpat  = tbl[v].wpat;
         noise = 1'b0;
         run_check(gd, ge, gs);
         chk("tbl.done_cycle", gd, tbl[v].exp_done);
         chk("tbl.err_cycle",  ge, tbl[v].exp_err);
         chk("tbl.swaps",      gs, tbl[v].exp_swaps);
      end

      for (int r = 0; r < 14; r++) begin
         int sel;
         clear_err();
         for (int i = 0; i < NSTEPS; i++) k_lat[i] = $urandom_range(1, TIMEOUT);
         sel   = $urandom_range(0, 3);
         fkind = (sel < 2) ? 0 : sel - 1;
         fat   = $urandom_range(0, NSTEPS - 1);
         pat   = 5'(1 << (fat % 5));
         wpat  = pat;
         while (wpat == pat) wpat = 5'($urandom_range(1, 31));
         noise = 1'b1;
         run_check(gd, ge, gs);
         chk("rnd.swaps", gs, (fkind != 0) ? fat : NSTEPS);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
